// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
//
// Owns the single register-file write port. After reset it walks through every
// register and writes zero to it (INIT). Once that is done (RUN), it shares the
// write port between two writeback requesters using valid/ready handshakes and
// round-robin priority. The write to the register file is registered, so a
// request accepted at edge k is written to the register file at edge k+1.
//
// Ports
//   clock      single clock, all state updates on its rising edge
//   reset_n    synchronous, active-low reset
//   wb0_*      writeback requester 0: valid/addr/data in, ready out
//   wb1_*      writeback requester 1: valid/addr/data in, ready out
//   rf_write   register-file RegWrite  (registered)
//   rf_waddr   register-file WriteReg  (registered)
//   rf_wdata   register-file WriteData (registered)
//   init_done  high once clearing has finished
//   addr_err   sticky flag: a request with an out-of-range register was taken
// ---------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 6,
    parameter int NUM_REGS = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wb0_valid,
    input  logic [ADDR_W-1:0] wb0_addr,
    input  logic [DATA_W-1:0] wb0_data,
    output logic              wb0_ready,
    input  logic              wb1_valid,
    input  logic [ADDR_W-1:0] wb1_addr,
    input  logic [DATA_W-1:0] wb1_data,
    output logic              wb1_ready,
    output logic              rf_write,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              init_done,
    output logic              addr_err
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX     = ADDR_W'(NUM_REGS - 1);
    // One bit wider so NUM_REGS == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]   NUM_REGS_EXT = (ADDR_W + 1)'(NUM_REGS);

    // True when the register number exists in the register file.
    function automatic logic addr_legal(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} < NUM_REGS_EXT);
    endfunction

    // True when an accepted request actually reaches the register file:
    // register 0 is hard-wired to zero, out-of-range numbers are discarded.
    function automatic logic addr_writes(input logic [ADDR_W-1:0] addr);
        return addr_legal(addr) && (addr != {ADDR_W{1'b0}});
    endfunction

    state_t              state_r;
    state_t              state_s;
    logic [ADDR_W-1:0]   idx_r;
    logic [ADDR_W-1:0]   idx_s;
    logic                rr_last_r;
    logic                rr_last_s;
    logic                rf_write_r;
    logic                rf_write_s;
    logic [ADDR_W-1:0]   rf_waddr_r;
    logic [ADDR_W-1:0]   rf_waddr_s;
    logic [DATA_W-1:0]   rf_wdata_r;
    logic [DATA_W-1:0]   rf_wdata_s;
    logic                addr_err_r;
    logic                addr_err_s;
    logic                grant0_s;
    logic                grant1_s;
    logic [ADDR_W-1:0]   acc_addr_s;
    logic [DATA_W-1:0]   acc_data_s;

    // Next-state, grant and write-port logic for both the clearing and run phases.
    always_comb begin
        grant0_s    = 1'b0;
        grant1_s    = 1'b0;
        acc_addr_s  = wb0_addr;
        acc_data_s  = wb0_data;
        state_s     = state_r;
        idx_s       = idx_r;
        rr_last_s   = rr_last_r;
        rf_write_s  = 1'b0;
        rf_waddr_s  = rf_waddr_r;
        rf_wdata_s  = rf_wdata_r;
        addr_err_s  = addr_err_r;

        case (state_r)
            ST_INIT: begin
                rf_write_s = 1'b1;
                rf_waddr_s = idx_r;
                rf_wdata_s = {DATA_W{1'b0}};
                idx_s      = idx_r + ADDR_W'(1);
                if (idx_r == LAST_IDX) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_INIT;
                end
            end

            ST_RUN: begin
                // rr_last names the port granted most recently; on contention
                // the other port wins.
                if (wb0_valid && wb1_valid) begin
                    grant0_s = rr_last_r;
                    grant1_s = ~rr_last_r;
                end else begin
                    grant0_s = wb0_valid;
                    grant1_s = wb1_valid;
                end

                if (grant1_s) begin
                    acc_addr_s = wb1_addr;
                    acc_data_s = wb1_data;
                    rr_last_s  = 1'b1;
                end else if (grant0_s) begin
                    acc_addr_s = wb0_addr;
                    acc_data_s = wb0_data;
                    rr_last_s  = 1'b0;
                end else begin
                    rr_last_s  = rr_last_r;
                end

                if (grant0_s || grant1_s) begin
                    rf_write_s = addr_writes(acc_addr_s);
                    rf_waddr_s = acc_addr_s;
                    rf_wdata_s = acc_data_s;
                    addr_err_s = addr_err_r | ~addr_legal(acc_addr_s);
                end else begin
                    rf_write_s = 1'b0;
                end
            end

            default: begin
                state_s = ST_INIT;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r    <= ST_INIT;
            idx_r      <= {ADDR_W{1'b0}};
            rr_last_r  <= 1'b1;
            rf_write_r <= 1'b0;
            rf_waddr_r <= {ADDR_W{1'b0}};
            rf_wdata_r <= {DATA_W{1'b0}};
            addr_err_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            idx_r      <= idx_s;
            rr_last_r  <= rr_last_s;
            rf_write_r <= rf_write_s;
            rf_waddr_r <= rf_waddr_s;
            rf_wdata_r <= rf_wdata_s;
            addr_err_r <= addr_err_s;
        end
    end

    assign wb0_ready = grant0_s;
    assign wb1_ready = grant1_s;
    assign rf_write  = rf_write_r;
    assign rf_waddr  = rf_waddr_r;
    assign rf_wdata  = rf_wdata_r;
    assign init_done = (state_r == ST_RUN);
    assign addr_err  = addr_err_r;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_write_arbiter
//
// Scoreboard bench: the stimulus process pushes every register-file write it
// expects into a queue; a monitor on the falling clock edge pops an entry each
// time the DUT asserts rf_write and compares address and data. Handshake,
// latency and status outputs are checked directly by the stimulus.
// ---------------------------------------------------------------------------
module tb_regfile_write_arbiter;

    logic        clock;
    logic        reset_n;
    logic        wb0_valid;
    logic [5:0]  wb0_addr;
    logic [63:0] wb0_data;
    logic        wb0_ready;
    logic        wb1_valid;
    logic [5:0]  wb1_addr;
    logic [63:0] wb1_data;
    logic        wb1_ready;
    logic        rf_write;
    logic [5:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic        init_done;
    logic        addr_err;

    typedef struct {
        logic [5:0]  addr;
        logic [63:0] data;
    } wr_t;

    wr_t  exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic mon_en  = 1'b0;
    logic exp_err = 1'b0;

    localparam logic [63:0] D3  = 64'hAAAA_0000_0000_0003;
    localparam logic [63:0] D7  = 64'hBBBB_0000_0000_0007;
    localparam logic [63:0] D5  = 64'hDEADBEEF_00000001;

    regfile_write_arbiter #(
        .DATA_W   (64),
        .ADDR_W   (6),
        .NUM_REGS (32)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .wb0_valid (wb0_valid),
        .wb0_addr  (wb0_addr),
        .wb0_data  (wb0_data),
        .wb0_ready (wb0_ready),
        .wb1_valid (wb1_valid),
        .wb1_addr  (wb1_addr),
        .wb1_data  (wb1_data),
        .wb1_ready (wb1_ready),
        .rf_write  (rf_write),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .init_done (init_done),
        .addr_err  (addr_err)
    );

    // Free-running clock, period 10.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected effect of an accepted request on the register file / error flag.
    task automatic expect_accept(input logic [5:0] a, input logic [63:0] d);
        wr_t e;
        if (a >= 6'd32) begin
            exp_err = 1'b1;
        end else if (a != 6'd0) begin
            e.addr = a;
            e.data = d;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: handshake sanity every cycle, scoreboard compare on every write.
    always @(negedge clock) begin
        wr_t e;
        if (mon_en) begin
            check("ready_exclusive", 64'(wb0_ready & wb1_ready), 64'd0);
            if (!init_done) begin
                check("ready_in_init", 64'(wb0_ready | wb1_ready), 64'd0);
            end
            if (rf_write === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write: got write to %0d expected no write", rf_waddr);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(rf_waddr), 64'(e.addr));
                    check("wr_data", rf_wdata, e.data);
                end
            end
        end
    end

    // Called at #1 after a posedge: one reset edge, check reset state, release.
    task automatic apply_reset();
        wr_t e;
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        check("rst_rf_write",  64'(rf_write),  64'd0);
        check("rst_rf_waddr",  64'(rf_waddr),  64'd0);
        check("rst_rf_wdata",  rf_wdata,       64'd0);
        check("rst_addr_err",  64'(addr_err),  64'd0);
        check("rst_init_done", 64'(init_done), 64'd0);
        exp_q.delete();
        exp_err = 1'b0;
        mon_en  = 1'b1;
        reset_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            e.addr = 6'(i);
            e.data = 64'd0;
            exp_q.push_back(e);
        end
    endtask

    // Clearing takes exactly 32 edges after release.
    task automatic wait_init();
        repeat (31) @(posedge clock);
        #1;
        check("init_done_edge31", 64'(init_done), 64'd0);
        @(posedge clock);
        #1;
        check("init_done_edge32", 64'(init_done), 64'd1);
    endtask

    // One request cycle: drive, check readys, record expected write, step an edge.
    task automatic req_cycle(input logic v0, input logic [5:0] a0, input logic [63:0] d0,
                             input logic v1, input logic [5:0] a1, input logic [63:0] d1,
                             input int exp_g);
        wb0_valid = v0; wb0_addr = a0; wb0_data = d0;
        wb1_valid = v1; wb1_addr = a1; wb1_data = d1;
        @(negedge clock);
        check("wb0_ready", 64'(wb0_ready), 64'(exp_g == 0));
        check("wb1_ready", 64'(wb1_ready), 64'(exp_g == 1));
        if (exp_g == 0) begin
            expect_accept(a0, d0);
        end else if (exp_g == 1) begin
            expect_accept(a1, d1);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        wb0_valid = 1'b0;
        wb1_valid = 1'b0;
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        wb0_valid = 1'b0; wb0_addr = 6'd0; wb0_data = 64'd0;
        wb1_valid = 1'b0; wb1_addr = 6'd0; wb1_data = 64'd0;
        @(posedge clock);
        #1;

        // Reset and full clearing sweep.
        apply_reset();
        wait_init();
        idle(2);
        check("init_drained", 64'(exp_q.size()), 64'd0);

        // Contention: round robin starting with port 0.
        req_cycle(1'b1, 6'd3, D3, 1'b1, 6'd7, D7, 0);
        req_cycle(1'b1, 6'd3, D3, 1'b1, 6'd7, D7, 1);
        req_cycle(1'b1, 6'd3, D3, 1'b1, 6'd7, D7, 0);
        req_cycle(1'b1, 6'd3, D3, 1'b1, 6'd7, D7, 1);
        check("rr_last_waddr", 64'(rf_waddr), 64'd7);
        idle(1);

        // No request: no grant.
        req_cycle(1'b0, 6'd4, D3, 1'b0, 6'd4, D7, -1);
        check("idle_no_write", 64'(rf_write), 64'd0);

        // Single request, one-cycle write latency.
        req_cycle(1'b1, 6'd5, D5, 1'b0, 6'd0, 64'd0, 0);
        check("lat_rf_write", 64'(rf_write), 64'd1);
        check("lat_rf_waddr", 64'(rf_waddr), 64'd5);
        check("lat_rf_wdata", rf_wdata, D5);

        // Register 0 is accepted but never written.
        req_cycle(1'b0, 6'd0, 64'd0, 1'b1, 6'd0, 64'h1234, 1);
        check("x0_no_write", 64'(rf_write), 64'd0);
        check("x0_no_err",   64'(addr_err), 64'd0);

        // Out-of-range numbers: accepted, dropped, sticky error.
        req_cycle(1'b1, 6'd32, 64'h5555, 1'b0, 6'd0, 64'd0, 0);
        check("oob32_no_write", 64'(rf_write), 64'd0);
        check("oob32_err",      64'(addr_err), 64'(exp_err));
        req_cycle(1'b0, 6'd0, 64'd0, 1'b1, 6'd40, 64'h6666, 1);
        check("oob40_no_write", 64'(rf_write), 64'd0);

        // Highest legal register is written; error stays set.
        req_cycle(1'b1, 6'd31, 64'h0000_0000_0000_0031, 1'b0, 6'd0, 64'd0, 0);
        check("r31_write", 64'(rf_write), 64'd1);
        idle(3);
        check("err_sticky", 64'(addr_err), 64'(exp_err));

        // Same register from both ports: port 1 first (port 0 won last), then port 0.
        req_cycle(1'b1, 6'd9, 64'h0909_0000, 1'b1, 6'd9, 64'h0909_0001, 1);
        req_cycle(1'b1, 6'd9, 64'h0909_0000, 1'b0, 6'd9, 64'h0909_0001, 0);
        check("same_addr_last", rf_wdata, 64'h0909_0000);
        idle(2);
        check("run_drained", 64'(exp_q.size()), 64'd0);

        // Reset during clearing, after register 10 was issued.
        reset_n = 1'b0;
        apply_reset();
        repeat (11) @(posedge clock);
        #1;
        check("mid_init_waddr", 64'(rf_waddr), 64'd10);
        apply_reset();
        wait_init();
        idle(2);
        check("reinit_drained", 64'(exp_q.size()), 64'd0);

        // Reset in RUN while both ports request: no readys during clearing,
        // port 0 wins first afterwards.
        wb0_valid = 1'b1; wb0_addr = 6'd12; wb0_data = 64'h0C0C;
        wb1_valid = 1'b1; wb1_addr = 6'd13; wb1_data = 64'h0D0D;
        apply_reset();
        check("run_rst_err", 64'(addr_err), 64'd0);
        wait_init();
        req_cycle(1'b1, 6'd12, 64'h0C0C, 1'b1, 6'd13, 64'h0D0D, 0);
        req_cycle(1'b0, 6'd12, 64'h0C0C, 1'b1, 6'd13, 64'h0D0D, 1);
        idle(3);
        check("final_drained", 64'(exp_q.size()), 64'd0);
        check("final_no_err",  64'(addr_err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
